// File: rtl/led_sequencer.sv
// -----------------------------------------------------------------------------
// led_sequencer
//
// Drives the board's 8 LEDs with one of four patterns (COUNT, SHIFT, BOUNCE,
// BLINK), advanced by an internal prescaled tick whose period is
// 2^(BASE_SHIFT+RATE) clocks. The front panel controls it with a RUN level
// (run/pause), a STEP pulse (single advance while paused) and a STOP pulse
// (back to idle, LEDs blanked).
//
// Build option:
//   LEDSEQ_GRAY_EN  when defined, COUNT mode shows the Gray code of the
//                   internal count instead of the plain binary count. The
//                   internal count, its wrap point and the other modes are
//                   unchanged.
// -----------------------------------------------------------------------------
module led_sequencer #(
  parameter int BASE_SHIFT = 17,
  parameter int CNT_W      = BASE_SHIFT + 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       RUN,
  input  logic       STEP,
  input  logic       STOP,
  input  logic [1:0] MODE,
  input  logic [2:0] RATE,
  output logic [7:0] LED,
  output logic       TICK,
  output logic       WRAP
);

  // Pattern selector values as seen on MODE.
  localparam logic [1:0] MODE_COUNT  = 2'd0;
  localparam logic [1:0] MODE_SHIFT  = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_BLINK  = 2'd3;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  state_t           state;
  logic [7:0]       pat;        // internal pattern value (binary count in COUNT)
  logic             dir_right;  // BOUNCE direction: 0 = moving left, 1 = right
  logic [1:0]       mode_q;     // MODE as seen on the previous edge
  logic [CNT_W-1:0] presc;

  logic [CNT_W-1:0] terminal;
  logic             tick_due;
  logic             mode_chg;
  logic [7:0]       init_val;
  logic [7:0]       adv_pat;
  logic             adv_dir;
  logic             adv_wrap;
  logic [7:0]       adv_led;

  // Starting pattern for a given mode.
  function automatic logic [7:0] init_pat(input logic [1:0] m);
    case (m)
      MODE_COUNT:  return 8'h00;
      MODE_SHIFT:  return 8'h01;
      MODE_BOUNCE: return 8'h01;
      default:     return 8'h55;
    endcase
  endfunction

  // Prescaler terminal count for the current RATE and the tick condition.
  // The compare is ">=" so that lowering RATE mid-period fires at once
  // instead of letting the prescaler run all the way around.
  always_comb begin
    terminal = (ONE << (BASE_SHIFT + int'(RATE))) - ONE;
    tick_due = (presc >= terminal);
    mode_chg = (MODE != mode_q);
    init_val = init_pat(MODE);
  end

  // One-step advance of the current pattern, plus its period-complete flag.
  // NOTE: every output of a combinational block is given a default first, so
  // no path through the case statement can leave a value unassigned and
  // infer a latch.
  always_comb begin
    adv_pat  = pat;
    adv_dir  = dir_right;
    adv_wrap = 1'b0;
    case (mode_q)
      MODE_COUNT: begin
        adv_pat  = pat + 8'd1;
        adv_wrap = (pat == 8'hFF);
      end
      MODE_SHIFT: begin
        adv_pat  = {pat[6:0], pat[7]};
        adv_wrap = (pat == 8'h80);
      end
      MODE_BOUNCE: begin
        if (!dir_right) begin
          // Moving left: turn around once the light lands on bit 7.
          adv_pat = pat << 1;
          adv_dir = (pat == 8'h40);
        end else begin
          // Moving right: turn around on bit 0; that landing closes a period.
          adv_pat  = pat >> 1;
          adv_dir  = (pat != 8'h02);
          adv_wrap = (pat == 8'h02);
        end
      end
      default: begin
        adv_pat  = (pat == 8'h55) ? 8'hAA : 8'h55;
        adv_wrap = (pat == 8'hAA);
      end
    endcase
  end

  // LED view of the advanced pattern. Initial values need no conversion:
  // the only one affected by the Gray option is COUNT's 0x00, which maps
  // to itself.
  always_comb begin
`ifdef LEDSEQ_GRAY_EN
    adv_led = (mode_q == MODE_COUNT) ? (adv_pat ^ (adv_pat >> 1)) : adv_pat;
`else
    adv_led = adv_pat;
`endif
  end

  // Control FSM with registered LED/TICK/WRAP; RESET overrides everything,
  // then STOP, then the per-state rules.
  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others, regardless of the
  // order the statements are written in.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= S_IDLE;
      pat       <= 8'h00;
      dir_right <= 1'b0;
      mode_q    <= 2'd0;
      presc     <= '0;
      LED       <= 8'h00;
      TICK      <= 1'b0;
      WRAP      <= 1'b0;
    end else begin
      mode_q <= MODE;
      TICK   <= 1'b0;
      WRAP   <= 1'b0;

      if (STOP) begin
        state     <= S_IDLE;
        pat       <= 8'h00;
        dir_right <= 1'b0;
        presc     <= '0;
        LED       <= 8'h00;
      end else begin
        case (state)
          S_IDLE: begin
            if (RUN) begin
              state     <= S_RUN;
              pat       <= init_val;
              dir_right <= 1'b0;
              presc     <= '0;
              LED       <= init_val;
            end
          end

          S_RUN: begin
            if (mode_chg) begin
              // New pattern restarts from its initial value; no advance now.
              state     <= RUN ? S_RUN : S_PAUSE;
              pat       <= init_val;
              dir_right <= 1'b0;
              presc     <= '0;
              LED       <= init_val;
            end else if (!RUN) begin
              // Pausing wins over a coincident tick; the LEDs freeze as-is.
              state <= S_PAUSE;
              presc <= '0;
            end else if (tick_due) begin
              pat       <= adv_pat;
              dir_right <= adv_dir;
              LED       <= adv_led;
              TICK      <= 1'b1;
              WRAP      <= adv_wrap;
              presc     <= '0;
            end else begin
              presc <= presc + ONE;
            end
          end

          S_PAUSE: begin
            if (mode_chg) begin
              state     <= RUN ? S_RUN : S_PAUSE;
              pat       <= init_val;
              dir_right <= 1'b0;
              presc     <= '0;
              LED       <= init_val;
            end else if (RUN) begin
              // RUN beats a simultaneous STEP: resume without stepping.
              state <= S_RUN;
              presc <= '0;
            end else if (STEP) begin
              pat       <= adv_pat;
              dir_right <= adv_dir;
              LED       <= adv_led;
              TICK      <= 1'b1;
              WRAP      <= adv_wrap;
            end
          end

          default: begin
            state <= S_IDLE;
            presc <= '0;
            LED   <= 8'h00;
          end
        endcase
      end
    end
  end

endmodule
